prod_bcd_display: RTL



---
 rtl/prod_bcd_display.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/prod_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : prod_bcd_display
// Purpose  : Captures an 8-bit product, converts it to 3-digit BCD with a
//            sequential double-dabble (one iteration per clock) and drives a
//            4-digit multiplexed active-low 7-segment display from the last
//            completed result.
// Revision : 1.0  initial release
// ============================================================================
module prod_bcd_display #(
    parameter int REFRESH_DIV   = 100000,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  prod_in,
    input  logic        prod_valid,
    output logic        busy,
    output logic [11:0] bcd_out,
    output logic        bcd_valid,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int               c_cnt_w     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REFRESH_DIV - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_conv = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [6:0] c_seg_blank = 7'b1111111;
    localparam logic [6:0] c_seg_zero  = 7'b1000000;

    // Conversion state
    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [7:0]  r_shift;
    logic [11:0] r_scratch;
    logic [11:0] w_adj;
    logic [2:0]  r_iter;
    logic [11:0] r_bcd;
    logic        r_bcd_valid;

    // Display state
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_wrap;
    logic [1:0]         r_idx;
    logic [1:0]         w_idx_next;
    logic [11:0]        w_bcd_next;
    logic               w_blank_hund;
    logic               w_blank_tens;
    logic [3:0]         w_an;
    logic [6:0]         w_seg;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;

    // Active-low decode of one BCD digit; non-decimal codes stay dark.
    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0010000;
            default: f_seg = c_seg_blank;
        endcase
    endfunction

    // Add-3 correction on every scratch nibble that would overflow after the shift.
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
        assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                  (r_scratch[4*gi +: 4] + 4'd3) : r_scratch[4*gi +: 4];
    end

    // Next-state logic: capture -> 8 iterations -> publish -> idle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (prod_valid) w_state_next = c_st_conv;
            c_st_conv: if (r_iter == 3'd7) w_state_next = c_st_done;
            c_st_done: w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_next;
    end

    // Conversion datapath: shift register, BCD scratch, iteration count, result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= 8'd0;
            r_scratch   <= 12'd0;
            r_iter      <= 3'd0;
            r_bcd       <= 12'd0;
            r_bcd_valid <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (prod_valid) begin
                        r_shift   <= prod_in;
                        r_scratch <= 12'd0;
                        r_iter    <= 3'd0;
                    end
                end
                c_st_conv: begin
                    r_scratch <= {w_adj[10:0], r_shift[7]};
                    r_shift   <= {r_shift[6:0], 1'b0};
                    r_iter    <= r_iter + 3'd1;
                end
                c_st_done: begin
                    r_bcd       <= r_scratch;
                    r_bcd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The display is decoded from the values the registers are about to take,
    // so an/seg always agree with the current scan index and bcd_out.
    assign w_wrap       = (r_cnt == c_cnt_max);
    assign w_idx_next   = w_wrap ? (r_idx + 2'd1) : r_idx;
    assign w_bcd_next   = (r_state == c_st_done) ? r_scratch : r_bcd;
    assign w_blank_hund = (BLANK_LEADING != 0) && (w_bcd_next[11:8] == 4'd0);
    assign w_blank_tens = w_blank_hund && (w_bcd_next[7:4] == 4'd0);

    // Digit enable and segment pattern for the upcoming scan position.
    always_comb begin
        w_an  = 4'b1111;
        w_seg = c_seg_blank;
        case (w_idx_next)
            2'd0: begin
                w_an  = 4'b1110;
                w_seg = f_seg(w_bcd_next[3:0]);
            end
            2'd1: begin
                w_an = 4'b1101;
                if (!w_blank_tens) w_seg = f_seg(w_bcd_next[7:4]);
            end
            2'd2: begin
                w_an = 4'b1011;
                if (!w_blank_hund) w_seg = f_seg(w_bcd_next[11:8]);
            end
            default: begin
                w_an  = 4'b0111;
                w_seg = c_seg_blank;
            end
        endcase
    end

    // Refresh counter, scan index and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
            r_an  <= 4'b1110;
            r_seg <= c_seg_zero;
        end else begin
            r_cnt <= w_wrap ? '0 : (r_cnt + 1'b1);
            r_idx <= w_idx_next;
            r_an  <= w_an;
            r_seg <= w_seg;
        end
    end

    assign busy      = (r_state != c_st_idle);
    assign bcd_out   = r_bcd;
    assign bcd_valid = r_bcd_valid;
    assign an        = r_an;
    assign seg       = r_seg;

endmodule
`default_nettype wire
